// File: rtl/ifmap_broadcast_ctrl.sv
// ifmap_broadcast_ctrl
//   Reads ifmap vectors from the show-ahead preload FIFO. Each vector is held
//   and sent to the MAC array reuse_total times, once per filter group, over a
//   valid/ready handshake. A job covers vec_total vectors. On the last reuse
//   beat the controller reads the next vector from the FIFO. If the FIFO is not
//   empty, the array therefore sees no idle cycle between vectors.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           one-cycle pulse; latches vec_total/reuse_total when idle
//   vec_total       number of vectors in the job
//   reuse_total     broadcasts per vector
//   fifo_empty      preload FIFO empty
//   fifo_dout       FIFO head (show-ahead), valid while !fifo_empty
//   fifo_read       pop FIFO head this cycle (combinational)
//   mac_ifmaps      held vector driven to the MAC array
//   mac_valid       mac_ifmaps valid
//   mac_ready       MAC array accepts the beat
//   mac_last_reuse  current beat is the last reuse of this vector
//   mac_last        current beat is the last beat of the job
//   busy            job in progress
//   done            one-cycle pulse at job completion
//   vec_cnt         index of the vector being broadcast
//   reuse_cnt       reuse index within the current vector
module ifmap_broadcast_ctrl #(
  parameter int MAC_NUM = 256,
  parameter int ELEM_W  = 5,
  parameter int CNT_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          vec_total,
  input  logic [CNT_W-1:0]          reuse_total,
  input  logic                      fifo_empty,
  input  logic [ELEM_W*MAC_NUM-1:0] fifo_dout,
  output logic                      fifo_read,
  output logic [ELEM_W*MAC_NUM-1:0] mac_ifmaps,
  output logic                      mac_valid,
  input  logic                      mac_ready,
  output logic                      mac_last_reuse,
  output logic                      mac_last,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          vec_cnt,
  output logic [CNT_W-1:0]          reuse_cnt
);

  localparam int VEC_W = ELEM_W * MAC_NUM;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [VEC_W-1:0]   hold_reg;
  logic [CNT_W-1:0]   vec_total_reg;
  logic [CNT_W-1:0]   reuse_total_reg;
  logic [CNT_W-1:0]   vec_cnt_reg;
  logic [CNT_W-1:0]   reuse_cnt_reg;
  logic               mac_valid_reg;
  logic               done_reg;

  logic               last_reuse;
  logic               last_vec;
  logic               beat_xfer;

  // The compare is done modulo 2^CNT_W. Totals of zero never reach SEND, so
  // the wrapped value of total-1 is never used.
  assign last_reuse = (reuse_cnt_reg == (reuse_total_reg - CNT_ONE));
  assign last_vec   = (vec_cnt_reg == (vec_total_reg - CNT_ONE));

  // mac_valid_reg is high exactly when the state is SEND.
  assign beat_xfer  = mac_valid_reg & mac_ready;

  // Pop in two cases: when entering SEND from FETCH, and as a prefetch on
  // the last reuse beat of a vector that is not the last vector. The term
  // !rst stops a pop in the cycle that aborts a job.
  assign fifo_read = ~rst & ~fifo_empty &
                     ((state_reg == FETCH) |
                      (beat_xfer & last_reuse & ~last_vec));

  assign mac_ifmaps     = hold_reg;
  assign mac_valid      = mac_valid_reg;
  assign mac_last_reuse = mac_valid_reg & last_reuse;
  assign mac_last       = mac_valid_reg & last_reuse & last_vec;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign vec_cnt        = vec_cnt_reg;
  assign reuse_cnt      = reuse_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      hold_reg        <= '0;
      vec_total_reg   <= '0;
      reuse_total_reg <= '0;
      vec_cnt_reg     <= '0;
      reuse_cnt_reg   <= '0;
      mac_valid_reg   <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            vec_total_reg   <= vec_total;
            reuse_total_reg <= reuse_total;
            vec_cnt_reg     <= '0;
            reuse_cnt_reg   <= '0;
            // A job with zero size finishes at once and never touches the FIFO.
            if ((vec_total == '0) || (reuse_total == '0)) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= FETCH;
            end
          end
        end

        FETCH: begin
          if (!fifo_empty) begin
            hold_reg      <= fifo_dout;
            state_reg     <= SEND;
            mac_valid_reg <= 1'b1;
          end
        end

        SEND: begin
          if (beat_xfer) begin
            if (!last_reuse) begin
              reuse_cnt_reg <= reuse_cnt_reg + CNT_ONE;
            end else if (!last_vec) begin
              reuse_cnt_reg <= '0;
              vec_cnt_reg   <= vec_cnt_reg + CNT_ONE;
              if (!fifo_empty) begin
                // The new vector is loaded in the same cycle, so the array
                // sees no idle cycle.
                hold_reg <= fifo_dout;
              end else begin
                state_reg     <= FETCH;
                mac_valid_reg <= 1'b0;
              end
            end else begin
              state_reg     <= IDLE;
              mac_valid_reg <= 1'b0;
              vec_cnt_reg   <= '0;
              reuse_cnt_reg <= '0;
              done_reg      <= 1'b1;
            end
          end
        end

        default: begin
          state_reg     <= IDLE;
          mac_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_broadcast_ctrl.sv
// Scoreboard bench for ifmap_broadcast_ctrl. The stimulus process queues the
// expected beats for each job. A negedge monitor pops and compares them when
// a beat transfers. The bench also models a show-ahead FIFO.
module tb_ifmap_broadcast_ctrl;

  localparam int MAC_NUM = 8;
  localparam int ELEM_W  = 5;
  localparam int CNT_W   = 12;
  localparam int W       = ELEM_W * MAC_NUM;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] vec_total;
  logic [CNT_W-1:0] reuse_total;
  logic             fifo_empty = 1'b1;
  logic [W-1:0]     fifo_dout = '0;
  logic             fifo_read;
  logic [W-1:0]     mac_ifmaps;
  logic             mac_valid;
  logic             mac_ready;
  logic             mac_last_reuse;
  logic             mac_last;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] reuse_cnt;

  ifmap_broadcast_ctrl #(.MAC_NUM(MAC_NUM), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_total(vec_total),
    .reuse_total(reuse_total), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(fifo_read), .mac_ifmaps(mac_ifmaps), .mac_valid(mac_valid),
    .mac_ready(mac_ready), .mac_last_reuse(mac_last_reuse), .mac_last(mac_last),
    .busy(busy), .done(done), .vec_cnt(vec_cnt), .reuse_cnt(reuse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     data;
    logic             lr;
    logic             l;
    logic [CNT_W-1:0] vc;
    logic [CNT_W-1:0] rc;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] jv [4];

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  int   beat_cnt = 0;
  int   exp_done_last = -1;
  int   exp_done_zero = -1;
  int   last_done_cyc = -1;
  logic pop_pending = 1'b0;
  logic toggle_en = 1'b0;

  logic             prev_stall = 1'b0;
  logic [W-1:0]     snap_data;
  logic [25:0]      snap_ctl;

  localparam logic [W-1:0] VA = 40'hA1_A2A3_A4A5;
  localparam logic [W-1:0] VB = 40'hB6_B7B8_B9BA;
  localparam logic [W-1:0] C0 = 40'h11_2233_4455;
  localparam logic [W-1:0] C1 = 40'h66_7788_99AA;
  localparam logic [W-1:0] C2 = 40'hBB_CCDD_EEFF;
  localparam logic [W-1:0] C3 = 40'h01_2345_6789;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // FIFO model. The pop is decided at the negedge and applied at the edge.
  // Head and empty are updated with NBAs so the DUT sees the values from
  // before the edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    fifo_dout  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    logic want_done;
    beat_t b;
    pop_pending = fifo_read;
    if (fifo_read) begin
      pop_cnt++;
      chk("read_while_empty", {63'd0, fifo_empty}, 64'd0);
    end
    if (prev_stall && mac_valid) begin
      chk("stall_data", {24'd0, mac_ifmaps}, {24'd0, snap_data});
      chk("stall_ctl", {38'd0, mac_last_reuse, mac_last, vec_cnt, reuse_cnt}, {38'd0, snap_ctl});
    end
    prev_stall = mac_valid && !mac_ready;
    snap_data  = mac_ifmaps;
    snap_ctl   = {mac_last_reuse, mac_last, vec_cnt, reuse_cnt};
    if (mac_valid && mac_ready) begin
      beat_cnt++;
      chk("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        $display("beat %0d: data=%h lr=%0b last=%0b vec=%0d reuse=%0d", beat_cnt,
                 mac_ifmaps, mac_last_reuse, mac_last, vec_cnt, reuse_cnt);
        chk("beat_data", {24'd0, mac_ifmaps}, {24'd0, b.data});
        chk("beat_flags", {62'd0, mac_last_reuse, mac_last}, {62'd0, b.lr, b.l});
        chk("beat_cnts", {40'd0, vec_cnt, reuse_cnt}, {40'd0, b.vc, b.rc});
      end
      if (mac_last) exp_done_last = cyc + 1;
    end
    want_done = (cyc == exp_done_last) || (cyc == exp_done_zero);
    if (done) last_done_cyc = cyc;
    if (want_done || done) chk("done_pulse", {63'd0, done}, {63'd0, want_done});
  end

  // Toggles mac_ready every cycle while enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (toggle_en) mac_ready = ~mac_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_job(input int vt, input int rt);
    beat_t b;
    for (int v = 0; v < vt; v++) begin
      for (int r = 0; r < rt; r++) begin
        b.data = jv[v];
        b.lr   = (r == rt - 1);
        b.l    = (r == rt - 1) && (v == vt - 1);
        b.vc   = CNT_W'(v);
        b.rc   = CNT_W'(r);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic pulse_start(input int vt, input int rt);
    vec_total   = CNT_W'(vt);
    reuse_total = CNT_W'(rt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_job(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk({name, "_complete"}, {63'd0, (exp_q.size() == 0) && !busy}, 64'd1);
    repeat (2) @(negedge clk);
    tick();
  endtask

  task automatic check_idle(input string name);
    chk({name, "_flags"}, {58'd0, mac_valid, fifo_read, mac_last_reuse, mac_last, busy, done}, 64'd0);
    chk({name, "_ifmaps"}, {24'd0, mac_ifmaps}, 64'd0);
    chk({name, "_cnts"}, {40'd0, vec_cnt, reuse_cnt}, 64'd0);
  endtask

  initial begin
    int p0, s, b0;
    rst = 1'b1; start = 1'b0; vec_total = '0; reuse_total = '0; mac_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle("reset");
    tick();
    rst = 1'b0;
    tick();

    // 1: two vectors, three reuses, no back-pressure
    fifo_q.push_back(VA); fifo_q.push_back(VB);
    jv[0] = VA; jv[1] = VB;
    expect_job(2, 3);
    mac_ready = 1'b1;
    p0 = pop_cnt; s = cyc;
    pulse_start(2, 3);
    wait_job("t1", 40);
    chk("t1_pops", 64'(pop_cnt - p0), 64'd2);
    chk("t1_latency", 64'(last_done_cyc - s), 64'd8);

    // 2: same job, mac_ready toggling
    fifo_q.push_back(VA); fifo_q.push_back(VB);
    expect_job(2, 3);
    mac_ready = 1'b1; toggle_en = 1'b1;
    p0 = pop_cnt;
    pulse_start(2, 3);
    wait_job("t2", 60);
    toggle_en = 1'b0; mac_ready = 1'b1;
    chk("t2_pops", 64'(pop_cnt - p0), 64'd2);

    // 3: second vector arrives late
    fifo_q.push_back(VA);
    expect_job(2, 3);
    p0 = pop_cnt; b0 = beat_cnt;
    pulse_start(2, 3);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (beat_cnt >= b0 + 3) break;
    end
    repeat (4) tick();
    @(negedge clk);
    chk("t3_fetch_wait", {61'd0, busy, mac_valid, fifo_read}, 64'd4);
    tick();
    fifo_q.push_back(VB);
    wait_job("t3", 40);
    chk("t3_pops", 64'(pop_cnt - p0), 64'd2);

    // 4: zero-size jobs
    fifo_q.push_back(VA);
    tick();
    p0 = pop_cnt;
    exp_done_zero = cyc + 1;
    pulse_start(0, 3);
    repeat (2) begin
      @(negedge clk);
      chk("t4a_quiet", {61'd0, busy, fifo_read, mac_valid}, 64'd0);
    end
    tick();
    exp_done_zero = cyc + 1;
    pulse_start(3, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t4b_quiet", {61'd0, busy, fifo_read, mac_valid}, 64'd0);
    end
    tick();
    chk("t4_pops", 64'(pop_cnt - p0), 64'd0);
    chk("t4_fifo_untouched", 64'(fifo_q.size()), 64'd1);
    fifo_q.delete();
    tick();

    // 5: reset after two beats, then a fresh job on the leftover word
    fifo_q.push_back(VA); fifo_q.push_back(VB);
    jv[0] = VA; jv[1] = VB;
    expect_job(2, 3);
    mac_ready = 1'b1;
    p0 = pop_cnt; b0 = beat_cnt;
    pulse_start(2, 3);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (beat_cnt >= b0 + 2) break;
    end
    #1;
    rst = 1'b1; mac_ready = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle("t5_after_rst");
    repeat (3) @(negedge clk);
    chk("t5_pops", 64'(pop_cnt - p0), 64'd1);
    chk("t5_fifo_left", 64'(fifo_q.size()), 64'd1);
    exp_q.delete();
    tick();
    jv[0] = VB;
    expect_job(1, 2);
    mac_ready = 1'b1;
    p0 = pop_cnt;
    pulse_start(1, 2);
    wait_job("t5_rerun", 30);
    chk("t5_rerun_pops", 64'(pop_cnt - p0), 64'd1);

    // 6: reuse_total=1 streaming, start mid-job ignored
    fifo_q.push_back(C0); fifo_q.push_back(C1); fifo_q.push_back(C2); fifo_q.push_back(C3);
    jv[0] = C0; jv[1] = C1; jv[2] = C2; jv[3] = C3;
    tick();
    expect_job(4, 1);
    p0 = pop_cnt; s = cyc;
    pulse_start(4, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_read%0d", i), {63'd0, fifo_read}, 64'd1);
      if (i == 0) begin
        start = 1'b1; vec_total = CNT_W'(1); reuse_total = CNT_W'(1);
      end else if (i == 1) begin
        start = 1'b0;
      end
    end
    wait_job("t6", 30);
    chk("t6_pops", 64'(pop_cnt - p0), 64'd4);
    chk("t6_latency", 64'(last_done_cyc - s), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
